// File: rtl/cache_mem_responder.sv
// Line-oriented main-memory responder for the cache controller.
// One request at a time: fixed wait, LINE_WORDS beats, then an MRdy pulse.
module cache_mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MDataValid,
  output logic              MDataReq,
  output logic              MRdy,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] base;
  logic              rw;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] addr;
  logic              cnt_zero;
  logic              last;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // base is line-aligned, so base + idx never leaves the line
  assign addr     = base + ADDR_W'(idx);
  assign cnt_zero = (cnt == '0);
  assign last     = (idx == IW'(LINE_WORDS - 1));
  assign wr_en    = (state == XFER) && rw && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (MStrobe) state_nx = WAIT;
      WAIT: if (cnt_zero) state_nx = XFER;
      XFER: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    MDataOut   = '0;
    MDataValid = 1'b0;
    MDataReq   = 1'b0;
    MRdy       = 1'b0;
    Busy       = (state != IDLE);
    if (state == XFER) begin
      if (rw) begin
        MDataReq = 1'b1;
      end else begin
        MDataValid = 1'b1;
        MDataOut   = mem[addr];
      end
    end
    if (state == DONE) MRdy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      rw   <= 1'b0;
      cnt  <= '0;
      idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MStrobe) begin
            base <= MAddr & ~ADDR_W'(LINE_WORDS - 1);
            rw   <= MRW;
            cnt  <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt_zero) idx <= '0;
          else cnt <= cnt - 1'b1;
        end
        XFER: if (!last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // array is outside reset: beats already written survive a reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= MDataIn;
  end

endmodule
